// File: rtl/period_meter.sv
// Measures the clk-cycle interval between successive rising edges of tick and
// presents it as period / load_val through a valid/ready handshake.
module period_meter #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] load_val,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overflow,
    output logic             dropped
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        SATURATED
    } state_t;

    // Largest count that can still be closed by an edge without cnt+1 wrapping.
    localparam logic [WIDTH-1:0] CNT_LIM = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tick_prev;

    logic w_edge;
    logic w_accept;
    logic w_result;
    logic w_ovf_set;
    logic w_drop_set;

    assign w_edge     = tick & ~r_tick_prev;
    assign w_accept   = period_valid & period_ready;
    assign w_result   = enable && (r_state == MEASURE) && w_edge;
    assign w_ovf_set  = enable && (r_state == MEASURE) && !w_edge && (r_cnt == CNT_LIM);
    assign w_drop_set = w_result && period_valid && !period_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_tick_prev  <= 1'b0;
            period       <= '0;
            load_val     <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            r_tick_prev <= tick;

            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: r_state <= ARM;
                    ARM: begin
                        if (w_edge) begin
                            r_cnt   <= '0;
                            r_state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (w_edge) begin
                            r_cnt <= '0;
                        end else if (r_cnt == CNT_LIM) begin
                            r_state <= SATURATED;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    SATURATED: begin
                        if (w_edge) begin
                            r_cnt   <= '0;
                            r_state <= MEASURE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end

            if (w_result) begin
                period       <= r_cnt + CNT_ONE;
                load_val     <= r_cnt;
                period_valid <= 1'b1;
            end else if (w_accept) begin
                period_valid <= 1'b0;
            end

            if (w_ovf_set) begin
                overflow <= 1'b1;
            end else if (w_accept) begin
                overflow <= 1'b0;
            end

            // A result landing on the accept cycle leaves dropped untouched.
            if (w_drop_set) begin
                dropped <= 1'b1;
            end else if (w_accept && !w_result) begin
                dropped <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: directed scenarios plus random tick/ready/enable
// traffic on a WIDTH=28 and a WIDTH=4 instance, checked against a timestamp model.
module tb_period_meter;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic tick;
    logic period_ready;

    logic [27:0] pa, la;
    logic        va, oa, da;
    logic [3:0]  pb, lb;
    logic        vb, ob, db;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    period_meter #(.WIDTH(28)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .period(pa), .load_val(la), .period_valid(va), .period_ready(period_ready),
        .overflow(oa), .dropped(da)
    );

    period_meter #(.WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .period(pb), .load_val(lb), .period_valid(vb), .period_ready(period_ready),
        .overflow(ob), .dropped(db)
    );

    // Reference model: measurement tracked as the cycle stamp of the start edge.
    localparam int P_OFF  = 0;  // disabled
    localparam int P_WAIT = 1;  // enabled, waiting for a start edge
    localparam int P_RUN  = 2;  // start edge seen, interval running
    localparam int P_LOST = 3;  // interval ran past the counter range

    longint      cyc = 0;
    logic        mprev;
    int          ph [2];
    longint      st [2];
    logic        mv [2];
    logic        mo [2];
    logic        md [2];
    logic [31:0] mp [2];
    logic [31:0] ml [2];

    function automatic int mw(input int i);
        return (i == 0) ? 28 : 4;
    endfunction

    task automatic model_reset();
        mprev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ph[i] = P_OFF; st[i] = 0;
            mv[i] = 1'b0; mo[i] = 1'b0; md[i] = 1'b0;
            mp[i] = 32'd0; ml[i] = 32'd0;
        end
    endtask

    task automatic model_step(input logic t, input logic r, input logic e);
        logic rise;
        rise = t && !mprev;
        mprev = t;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic   res, ovf, acc;
            longint interval;
            res = 1'b0; ovf = 1'b0; interval = 0;
            acc = mv[i] && r;
            if (!e) begin
                ph[i] = P_OFF;
            end else if (ph[i] == P_OFF) begin
                ph[i] = P_WAIT;
            end else if (ph[i] == P_WAIT || ph[i] == P_LOST) begin
                if (rise) begin st[i] = cyc; ph[i] = P_RUN; end
            end else begin
                if (rise) begin
                    res = 1'b1; interval = cyc - st[i]; st[i] = cyc;
                end else if (cyc - st[i] >= (longint'(1) << mw(i)) - 1) begin
                    ovf = 1'b1; ph[i] = P_LOST;
                end
            end
            if (res && mv[i] && !r) md[i] = 1'b1;
            else if (acc && !res)   md[i] = 1'b0;
            if (ovf)      mo[i] = 1'b1;
            else if (acc) mo[i] = 1'b0;
            if (res) begin
                mp[i] = 32'(interval); ml[i] = 32'(interval - 1); mv[i] = 1'b1;
            end else if (acc) begin
                mv[i] = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("A_period",   {4'd0, pa},  mp[0]);
        check("A_load_val", {4'd0, la},  ml[0]);
        check("A_valid",    {31'd0, va}, {31'd0, mv[0]});
        check("A_overflow", {31'd0, oa}, {31'd0, mo[0]});
        check("A_dropped",  {31'd0, da}, {31'd0, md[0]});
        check("B_period",   {28'd0, pb}, mp[1]);
        check("B_load_val", {28'd0, lb}, ml[1]);
        check("B_valid",    {31'd0, vb}, {31'd0, mv[1]});
        check("B_overflow", {31'd0, ob}, {31'd0, mo[1]});
        check("B_dropped",  {31'd0, db}, {31'd0, md[1]});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_A_period"},  {4'd0, pa},  32'd0);
        check({tag, "_A_load"},    {4'd0, la},  32'd0);
        check({tag, "_A_valid"},   {31'd0, va}, 32'd0);
        check({tag, "_A_ovf"},     {31'd0, oa}, 32'd0);
        check({tag, "_A_drop"},    {31'd0, da}, 32'd0);
        check({tag, "_B_period"},  {28'd0, pb}, 32'd0);
        check({tag, "_B_valid"},   {31'd0, vb}, 32'd0);
        check({tag, "_B_ovf"},     {31'd0, ob}, 32'd0);
    endtask

    task automatic apply(input logic t, input logic r, input logic e);
        tick = t; period_ready = r; enable = e;
        model_step(t, r, e);
    endtask

    task automatic drive(input logic t, input logic r, input logic e);
        @(negedge clk);
        check_all();
        apply(t, r, e);
    endtask

    task automatic gap(input int k, input logic r);
        drive(1'b1, r, 1'b1);
        repeat (k - 1) drive(1'b0, r, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dens;
        reset = 1'b0; enable = 1'b0; tick = 1'b0; period_ready = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0);

        // Steady 5-cycle pulses, consumer always ready
        drive(1'b0, 1'b1, 1'b1);
        repeat (6) gap(5, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        check("s5_A_period", {4'd0, pa}, 32'd5);
        check("s5_A_load",   {4'd0, la}, 32'd4);
        check("s5_B_period", {28'd0, pb}, 32'd5);

        // Unconsumed results: 10 then 7, then a single accept
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        gap(10, 1'b0);
        gap(7, 1'b0);
        check("s10_A_period", {4'd0, pa}, 32'd10);
        check("s10_A_valid",  {31'd0, va}, 32'd1);
        check("s10_A_drop",   {31'd0, da}, 32'd0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        check("s7_A_period", {4'd0, pa}, 32'd7);
        check("s7_A_load",   {4'd0, la}, 32'd6);
        check("s7_A_drop",   {31'd0, da}, 32'd1);
        check("s7_A_valid",  {31'd0, va}, 32'd1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("acc_A_valid", {31'd0, va}, 32'd0);
        check("acc_A_drop",  {31'd0, da}, 32'd0);

        // Long silence overflows the 4-bit instance only
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        repeat (20) drive(1'b0, 1'b0, 1'b1);
        check("ovf_B_overflow", {31'd0, ob}, 32'd1);
        check("ovf_B_valid",    {31'd0, vb}, 32'd0);
        check("ovf_A_overflow", {31'd0, oa}, 32'd0);
        gap(3, 1'b0);
        gap(3, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        check("ovf_B_period",   {28'd0, pb}, 32'd3);
        check("ovf_B_load",     {28'd0, lb}, 32'd2);
        check("ovf_B_overflow2", {31'd0, ob}, 32'd1);
        repeat (2) drive(1'b0, 1'b1, 1'b1);
        check("clr_B_overflow", {31'd0, ob}, 32'd0);

        // Tick held high: one edge only
        repeat (8) drive(1'b1, 1'b1, 1'b1);
        repeat (10) drive(1'b0, 1'b1, 1'b1);
        repeat (3) gap(4, 1'b1);

        // Enable dropped mid-interval, then 6-cycle edges after re-arm
        gap(6, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        repeat (2) drive(1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b1);
        repeat (3) gap(6, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        check("en_A_period", {4'd0, pa}, 32'd6);
        check("en_B_period", {28'd0, pb}, 32'd6);

        // Asynchronous reset while a 9-cycle result is pending
        repeat (3) gap(9, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("r9_A_period", {4'd0, pa}, 32'd9);
        check("r9_A_valid",  {31'd0, va}, 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1 check_zero("async");
        @(negedge clk);
        check_all();
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b1);

        // Random traffic
        dens = 4;
        for (int n = 0; n < 3000; n++) begin
            logic t, r, e;
            if (n % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: dens = 0;
                    1: dens = 2;
                    2: dens = 6;
                    default: dens = 25;
                endcase
            end
            t = ($urandom_range(0, dens) == 0);
            r = ((n / 100) % 3 == 0) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 149) != 0);
            drive(t, r, e);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                #1 check_zero("rnd_reset");
                @(posedge clk);
                #1 reset = 1'b0;
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
